// File: rtl/avalon_st_pkt_tx_if.sv
// Write-port and Avalon-ST source bundle for avalon_st_pkt_tx.
// The slave modport is the transmitter side; master is the producer/sink side.
interface avalon_st_pkt_tx_if #(
    parameter int unsigned DWIDTH      = 6,
    parameter int unsigned MAX_PKT_LEN = 10
);
    localparam int unsigned PW = $clog2(MAX_PKT_LEN) + 1;

    logic [DWIDTH-1:0] wr_data;
    logic              wr_valid;
    logic              wr_last;
    logic              wr_ready;
    logic              src_ready;
    logic [DWIDTH-1:0] src_data;
    logic              src_valid;
    logic              src_startofpacket;
    logic              src_endofpacket;
    logic [PW-1:0]     pkt_len;
    logic              trunc;

    modport master (
        output wr_data, wr_valid, wr_last, src_ready,
        input  wr_ready, src_data, src_valid, src_startofpacket, src_endofpacket,
               pkt_len, trunc
    );

    modport slave (
        input  wr_data, wr_valid, wr_last, src_ready,
        output wr_ready, src_data, src_valid, src_startofpacket, src_endofpacket,
               pkt_len, trunc
    );
endinterface

// File: rtl/avalon_st_pkt_tx.sv
// Buffers one packet from a simple write port, then replays it as an
// Avalon-ST packet (ready latency 0) with SOP/EOP and length/truncation status.
module avalon_st_pkt_tx #(
    parameter int unsigned DWIDTH      = 6,
    parameter int unsigned MAX_PKT_LEN = 10
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    avalon_st_pkt_tx_if.slave      bus
);
    localparam int unsigned PW = $clog2(MAX_PKT_LEN) + 1;
    localparam int unsigned AW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;

    typedef enum logic {LOAD_S, SEND_S} state_t;

    state_t            state;
    logic [DWIDTH-1:0] mem [MAX_PKT_LEN];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_nxt;
    logic [PW-1:0]     rd_ptr_nxt;
    logic              accept;
    logic              load_done;

    assign accept     = bus.wr_valid && bus.wr_ready;
    assign wr_ptr_nxt = PW'(wr_ptr + 1'b1);
    assign rd_ptr_nxt = PW'(rd_ptr + 1'b1);
    assign load_done  = accept && (bus.wr_last || (wr_ptr_nxt == PW'(MAX_PKT_LEN)));

    // Packet storage; contents are don't-care outside a loaded packet.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[AW'(wr_ptr)] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state                 <= LOAD_S;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            bus.wr_ready          <= 1'b0;
            bus.src_valid         <= 1'b0;
            bus.src_data          <= '0;
            bus.src_startofpacket <= 1'b0;
            bus.src_endofpacket   <= 1'b0;
            bus.pkt_len           <= '0;
            bus.trunc             <= 1'b0;
        end else begin
            case (state)
                LOAD_S: begin
                    bus.wr_ready <= !load_done;
                    if (accept) begin
                        wr_ptr <= wr_ptr_nxt;
                        if (wr_ptr == '0) begin
                            bus.trunc <= 1'b0;
                        end
                        if (load_done) begin
                            state                 <= SEND_S;
                            rd_ptr                <= '0;
                            bus.pkt_len           <= wr_ptr_nxt;
                            bus.trunc             <= !bus.wr_last;
                            bus.src_valid         <= 1'b1;
                            bus.src_startofpacket <= 1'b1;
                            bus.src_endofpacket   <= (wr_ptr == '0);
                            // A single-word packet is not yet in the buffer, so bypass it.
                            bus.src_data          <= (wr_ptr == '0) ? bus.wr_data : mem[0];
                        end
                    end
                end
                SEND_S: begin
                    if (bus.src_ready) begin
                        if (bus.src_endofpacket) begin
                            state                 <= LOAD_S;
                            wr_ptr                <= '0;
                            rd_ptr                <= '0;
                            bus.wr_ready          <= 1'b1;
                            bus.src_valid         <= 1'b0;
                            bus.src_data          <= '0;
                            bus.src_startofpacket <= 1'b0;
                            bus.src_endofpacket   <= 1'b0;
                        end else begin
                            rd_ptr                <= rd_ptr_nxt;
                            bus.src_data          <= mem[AW'(rd_ptr_nxt)];
                            bus.src_startofpacket <= 1'b0;
                            bus.src_endofpacket   <= (rd_ptr_nxt == PW'(bus.pkt_len - 1'b1));
                        end
                    end
                end
                default: state <= LOAD_S;
            endcase
        end
    end
endmodule
